// File: rtl/wf68k30l_div_writeback_pkg.sv
// Shared constants for the WF68K30L divide write-back path: opcodes, operand sizes,
// and the write-back sequencer state type.
package wf68k30l_div_writeback_pkg;

  localparam logic [6:0] DIVS = 7'd24;
  localparam logic [6:0] DIVU = 7'd25;

  localparam logic [1:0] LONG = 2'd0;
  localparam logic [1:0] WORD = 2'd1;
  localparam logic [1:0] BYTE = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StWbQ,
    StWbR,
    StFin
  } div_wb_states_t;

endpackage

// File: rtl/wf68k30l_div_writeback_if.sv
// Bundles the ALU start fields, the divider result bus and the register-file write port
// of the divide write-back stage.
interface wf68k30l_div_writeback_if;

  logic        ALU_INIT;
  logic [6:0]  OP_IN;
  logic [1:0]  OP_SIZE;
  logic [15:0] BIW_1;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [31:0] OP3;
  logic        DIV_ZERO;
  logic        DIV_RDY;
  logic [31:0] QUOTIENT;
  logic [31:0] REMAINDER;
  logic        VFLAG_DIV;
  logic        WB_ACK;
  logic        WB_VALID;
  logic [2:0]  WB_REG;
  logic [31:0] WB_DATA;
  logic [3:0]  CCR_NZVC;
  logic        CCR_VALID;
  logic        TRAP_DIVZERO;
  logic        BUSY;
  logic        DONE;

  modport master (
    output ALU_INIT, OP_IN, OP_SIZE, BIW_1, OP1, OP2, OP3,
    output DIV_ZERO, DIV_RDY, QUOTIENT, REMAINDER, VFLAG_DIV, WB_ACK,
    input  WB_VALID, WB_REG, WB_DATA, CCR_NZVC, CCR_VALID, TRAP_DIVZERO, BUSY, DONE
  );

  modport slave (
    input  ALU_INIT, OP_IN, OP_SIZE, BIW_1, OP1, OP2, OP3,
    input  DIV_ZERO, DIV_RDY, QUOTIENT, REMAINDER, VFLAG_DIV, WB_ACK,
    output WB_VALID, WB_REG, WB_DATA, CCR_NZVC, CCR_VALID, TRAP_DIVZERO, BUSY, DONE
  );

endinterface

// File: rtl/wf68k30l_div_writeback_signfix.sv
// Remainder sign correction, DIVS range check and quotient N/Z flags (purely combinational).
// The range check is built only when WF68K30L_DIVS_OVF_CHECK_EN is defined.
module wf68k30l_div_writeback_signfix (
  input  logic        i_is_divs,
  input  logic        i_is_long,
  input  logic        i_dvd_neg,
  input  logic        i_dvs_neg,
  input  logic [31:0] i_quotient,
  input  logic [31:0] i_remainder,
  output logic        o_signed_ovf,
  output logic [31:0] o_rem,
  output logic        o_flag_n,
  output logic        o_flag_z
);

  // The divider delivers a magnitude; the remainder takes the dividend's sign.
  assign o_rem    = (i_is_divs && i_dvd_neg) ? (32'd0 - i_remainder) : i_remainder;
  assign o_flag_n = i_is_long ? i_quotient[31] : i_quotient[15];
  assign o_flag_z = i_is_long ? (i_quotient == 32'd0) : (i_quotient[15:0] == 16'd0);

`ifdef WF68K30L_DIVS_OVF_CHECK_EN
  logic w_word_ovf;
  logic w_long_ovf;

  // In range for a 16-bit signed result when bits 31..15 are all equal.
  assign w_word_ovf = !((i_quotient[31:15] == 17'h00000) || (i_quotient[31:15] == 17'h1ffff));
  assign w_long_ovf = (i_dvd_neg == i_dvs_neg) ? i_quotient[31]
                                               : ((i_quotient != 32'd0) && !i_quotient[31]);
  assign o_signed_ovf = i_is_divs && (i_is_long ? w_long_ovf : w_word_ovf);
`else
  logic w_unused_dvs_neg;

  assign w_unused_dvs_neg = i_dvs_neg;
  assign o_signed_ovf     = 1'b0;
`endif

endmodule

// File: rtl/wf68k30l_div_writeback.sv
// Divide write-back stage: latches operand signs at start, turns divider results into CCR
// flags and sequences the Dq/Dr register writes. Optional macro: WF68K30L_DIVS_OVF_CHECK_EN.
module wf68k30l_div_writeback
  import wf68k30l_div_writeback_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RESET_N,
  wf68k30l_div_writeback_if.slave      bus
);

  div_wb_states_t r_state, w_state_d;

  logic        r_is_divs, r_is_long, r_dvd_neg, r_dvs_neg;
  logic [2:0]  r_dq, r_dr;
  logic [31:0] r_rem;
  logic        r_wb_valid, w_wb_valid_d;
  logic [2:0]  r_wb_reg, w_wb_reg_d;
  logic [31:0] r_wb_data, w_wb_data_d;
  logic [3:0]  r_ccr, w_ccr_d;
  logic        r_ccr_valid, w_ccr_valid_d;
  logic        r_trap, w_trap_d;
  logic        r_done, w_done_d;

  logic        w_arm, w_rdy, w_ovf, w_signed_ovf, w_flag_n, w_flag_z, w_second_write;
  logic [31:0] w_rem_fix;

  // A new DIVS/DIVU start is taken in IDLE and restarts a pending ARMED operation.
  assign w_arm = bus.ALU_INIT && ((bus.OP_IN == DIVS) || (bus.OP_IN == DIVU)) &&
                 ((r_state == StIdle) || (r_state == StArmed));
  assign w_rdy = (r_state == StArmed) && bus.DIV_RDY && !w_arm;
  assign w_ovf = bus.VFLAG_DIV | w_signed_ovf;
  assign w_second_write = r_is_long && (r_dr != r_dq);

  wf68k30l_div_writeback_signfix u_signfix (
    .i_is_divs    (r_is_divs),
    .i_is_long    (r_is_long),
    .i_dvd_neg    (r_dvd_neg),
    .i_dvs_neg    (r_dvs_neg),
    .i_quotient   (bus.QUOTIENT),
    .i_remainder  (bus.REMAINDER),
    .o_signed_ovf (w_signed_ovf),
    .o_rem        (w_rem_fix),
    .o_flag_n     (w_flag_n),
    .o_flag_z     (w_flag_z)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_arm) w_state_d = StArmed;
      StArmed: if (w_rdy) w_state_d = (bus.DIV_ZERO || w_ovf) ? StFin : StWbQ;
      StWbQ:   if (bus.WB_ACK) w_state_d = w_second_write ? StWbR : StFin;
      StWbR:   if (bus.WB_ACK) w_state_d = StFin;
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_wb_valid_d  = r_wb_valid;
    w_wb_reg_d    = r_wb_reg;
    w_wb_data_d   = r_wb_data;
    w_ccr_d       = r_ccr;
    w_ccr_valid_d = 1'b0;
    w_trap_d      = 1'b0;
    w_done_d      = (r_state == StFin);
    if (w_rdy) begin
      if (bus.DIV_ZERO) begin
        w_trap_d = 1'b1;
      end else if (w_ovf) begin
        w_ccr_d       = 4'b0010;
        w_ccr_valid_d = 1'b1;
      end else begin
        w_ccr_d       = {w_flag_n, w_flag_z, 2'b00};
        w_ccr_valid_d = 1'b1;
        w_wb_valid_d  = 1'b1;
        w_wb_reg_d    = r_dq;
        w_wb_data_d   = r_is_long ? bus.QUOTIENT : {w_rem_fix[15:0], bus.QUOTIENT[15:0]};
      end
    end else if ((r_state == StWbQ) && bus.WB_ACK) begin
      if (w_second_write) begin
        w_wb_reg_d  = r_dr;
        w_wb_data_d = r_rem;
      end else begin
        w_wb_valid_d = 1'b0;
      end
    end else if ((r_state == StWbR) && bus.WB_ACK) begin
      w_wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_is_divs   <= 1'b0;
      r_is_long   <= 1'b0;
      r_dvd_neg   <= 1'b0;
      r_dvs_neg   <= 1'b0;
      r_dq        <= 3'd0;
      r_dr        <= 3'd0;
      r_rem       <= 32'd0;
      r_wb_valid  <= 1'b0;
      r_wb_reg    <= 3'd0;
      r_wb_data   <= 32'd0;
      r_ccr       <= 4'd0;
      r_ccr_valid <= 1'b0;
      r_trap      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_arm) begin
        r_is_divs <= (bus.OP_IN == DIVS);
        r_is_long <= (bus.OP_SIZE == LONG);
        r_dq      <= bus.BIW_1[14:12];
        r_dr      <= bus.BIW_1[2:0];
        r_dvd_neg <= ((bus.OP_SIZE == LONG) && bus.BIW_1[10]) ? bus.OP3[31] : bus.OP2[31];
        r_dvs_neg <= (bus.OP_SIZE == WORD) ? bus.OP1[15] : bus.OP1[31];
      end
      if (w_rdy) r_rem <= w_rem_fix;
      r_wb_valid  <= w_wb_valid_d;
      r_wb_reg    <= w_wb_reg_d;
      r_wb_data   <= w_wb_data_d;
      r_ccr       <= w_ccr_d;
      r_ccr_valid <= w_ccr_valid_d;
      r_trap      <= w_trap_d;
      r_done      <= w_done_d;
    end
  end

  assign bus.WB_VALID     = r_wb_valid;
  assign bus.WB_REG       = r_wb_reg;
  assign bus.WB_DATA      = r_wb_data;
  assign bus.CCR_NZVC     = r_ccr;
  assign bus.CCR_VALID    = r_ccr_valid;
  assign bus.TRAP_DIVZERO = r_trap;
  assign bus.BUSY         = (r_state != StIdle);
  assign bus.DONE         = r_done;

endmodule

// File: tb/tb_wf68k30l_div_writeback.sv
// Directed bench for the divide write-back stage; expected values are hand-computed.
module tb_wf68k30l_div_writeback;
  import wf68k30l_div_writeback_pkg::*;

  logic CLK;
  logic RESET_N;
  int   n_cmp;
  int   n_err;

  wf68k30l_div_writeback_if bus ();

  wf68k30l_div_writeback dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [6:0] op, input logic [1:0] sz, input logic [15:0] biw,
                          input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3);
    bus.ALU_INIT = 1'b1;
    bus.OP_IN    = op;
    bus.OP_SIZE  = sz;
    bus.BIW_1    = biw;
    bus.OP1      = o1;
    bus.OP2      = o2;
    bus.OP3      = o3;
    tick();
    bus.ALU_INIT = 1'b0;
    bus.OP1      = 32'd0;
    bus.OP2      = 32'd0;
    bus.OP3      = 32'd0;
  endtask

  task automatic div_rdy(input logic [31:0] q, input logic [31:0] r, input logic vf,
                         input logic dz);
    bus.DIV_RDY   = 1'b1;
    bus.QUOTIENT  = q;
    bus.REMAINDER = r;
    bus.VFLAG_DIV = vf;
    bus.DIV_ZERO  = dz;
    tick();
    bus.DIV_RDY   = 1'b0;
    bus.QUOTIENT  = 32'hdead_beef;
    bus.REMAINDER = 32'hdead_beef;
    bus.VFLAG_DIV = 1'b0;
    bus.DIV_ZERO  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET_N       = 1'b0;
    bus.ALU_INIT  = 1'b0;
    bus.OP_IN     = 7'd0;
    bus.OP_SIZE   = WORD;
    bus.BIW_1     = 16'd0;
    bus.OP1       = 32'd0;
    bus.OP2       = 32'd0;
    bus.OP3       = 32'd0;
    bus.DIV_ZERO  = 1'b0;
    bus.DIV_RDY   = 1'b0;
    bus.QUOTIENT  = 32'd0;
    bus.REMAINDER = 32'd0;
    bus.VFLAG_DIV = 1'b0;
    bus.WB_ACK    = 1'b0;

    #3;
    check("rst_wb_valid", bus.WB_VALID, 0);
    check("rst_wb_reg", bus.WB_REG, 0);
    check("rst_wb_data", bus.WB_DATA, 0);
    check("rst_ccr", bus.CCR_NZVC, 0);
    check("rst_ccr_valid", bus.CCR_VALID, 0);
    check("rst_trap", bus.TRAP_DIVZERO, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    RESET_N = 1'b1;
    tick();

    // Stray DIV_RDY and a non-divide start must leave the block idle.
    div_rdy(32'd5, 32'd1, 1'b0, 1'b0);
    check("idle_rdy_ccr_valid", bus.CCR_VALID, 0);
    check("idle_rdy_busy", bus.BUSY, 0);
    start_op(7'd3, WORD, 16'h1000, 32'd1, 32'd1, 32'd0);
    check("nondiv_busy", bus.BUSY, 0);

    // DIVU.W 100/7 -> Q=14 R=2, Dq=3
    start_op(DIVU, WORD, 16'h3000, 32'd7, 32'd100, 32'd0);
    check("divuw_busy", bus.BUSY, 1);
    div_rdy(32'd14, 32'd2, 1'b0, 1'b0);
    check("divuw_ccr_valid", bus.CCR_VALID, 1);
    check("divuw_ccr", bus.CCR_NZVC, 4'b0000);
    check("divuw_wb_valid", bus.WB_VALID, 1);
    check("divuw_wb_reg", bus.WB_REG, 3);
    check("divuw_wb_data", bus.WB_DATA, 32'h0002_000E);
    bus.WB_ACK = 1'b1;
    tick();
    bus.WB_ACK = 1'b0;
    check("divuw_valid_drop", bus.WB_VALID, 0);
    check("divuw_ccr_valid_pulse", bus.CCR_VALID, 0);
    tick();
    check("divuw_done", bus.DONE, 1);
    check("divuw_idle", bus.BUSY, 0);
    tick();
    check("divuw_done_pulse", bus.DONE, 0);

    // DIVS.W -7/2 -> Q=-3 R=-1, Dq=5
    start_op(DIVS, WORD, 16'h5000, 32'd2, 32'hFFFF_FFF9, 32'd0);
    div_rdy(32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    check("divsw_ccr", bus.CCR_NZVC, 4'b1000);
    check("divsw_wb_reg", bus.WB_REG, 5);
    check("divsw_wb_data", bus.WB_DATA, 32'hFFFF_FFFD);
    bus.WB_ACK = 1'b1;
    tick();
    bus.WB_ACK = 1'b0;
    tick();
    check("divsw_done", bus.DONE, 1);

    // DIVS.L 0x80000000 / -1, Dq=Dr=3
    start_op(DIVS, LONG, 16'h3003, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    div_rdy(32'h8000_0000, 32'd0, 1'b0, 1'b0);
    check("divsl_ccr_valid", bus.CCR_VALID, 1);
`ifdef WF68K30L_DIVS_OVF_CHECK_EN
    check("divsl_ccr", bus.CCR_NZVC, 4'b0010);
    check("divsl_no_write", bus.WB_VALID, 0);
    tick();
    check("divsl_done", bus.DONE, 1);
`else
    check("divsl_ccr", bus.CCR_NZVC, 4'b1000);
    check("divsl_wb_valid", bus.WB_VALID, 1);
    check("divsl_wb_data", bus.WB_DATA, 32'h8000_0000);
    bus.WB_ACK = 1'b1;
    tick();
    bus.WB_ACK = 1'b0;
    check("divsl_single_write", bus.WB_VALID, 0);
    tick();
    check("divsl_done", bus.DONE, 1);
`endif

    // DIVU.W divider overflow flag -> V only, no write
    start_op(DIVU, WORD, 16'h4000, 32'd1, 32'h0010_0000, 32'd0);
    div_rdy(32'h0010_0000, 32'd0, 1'b1, 1'b0);
    check("vflag_ccr", bus.CCR_NZVC, 4'b0010);
    check("vflag_no_write", bus.WB_VALID, 0);
    tick();
    check("vflag_done", bus.DONE, 1);

    // DIVU.L 64-bit, Dq=2 Dr=1, ack held off for 3 cycles
    start_op(DIVU, LONG, 16'h2401, 32'd3, 32'd0, 32'd1);
    div_rdy(32'h1234_5678, 32'd9, 1'b0, 1'b0);
    check("divul_ccr", bus.CCR_NZVC, 4'b0000);
    check("divul_q_valid", bus.WB_VALID, 1);
    check("divul_q_reg", bus.WB_REG, 2);
    check("divul_q_data", bus.WB_DATA, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("divul_hold_valid", bus.WB_VALID, 1);
      check("divul_hold_reg", bus.WB_REG, 2);
      check("divul_hold_data", bus.WB_DATA, 32'h1234_5678);
    end
    bus.WB_ACK = 1'b1;
    tick();
    check("divul_r_valid", bus.WB_VALID, 1);
    check("divul_r_reg", bus.WB_REG, 1);
    check("divul_r_data", bus.WB_DATA, 32'd9);
    tick();
    bus.WB_ACK = 1'b0;
    check("divul_r_drop", bus.WB_VALID, 0);
    check("divul_r_not_done", bus.DONE, 0);
    tick();
    check("divul_done", bus.DONE, 1);

    // Divide by zero
    start_op(DIVU, WORD, 16'h1000, 32'd0, 32'd10, 32'd0);
    div_rdy(32'd0, 32'd0, 1'b0, 1'b1);
    check("dz_trap", bus.TRAP_DIVZERO, 1);
    check("dz_ccr_valid", bus.CCR_VALID, 0);
    check("dz_no_write", bus.WB_VALID, 0);
    tick();
    check("dz_trap_pulse", bus.TRAP_DIVZERO, 0);
    check("dz_done", bus.DONE, 1);

    // Asynchronous reset while the Dr write is pending
    start_op(DIVU, LONG, 16'h2401, 32'd3, 32'd0, 32'd1);
    div_rdy(32'h0000_00AA, 32'd7, 1'b0, 1'b0);
    bus.WB_ACK = 1'b1;
    tick();
    bus.WB_ACK = 1'b0;
    check("rstmid_in_wbr", bus.WB_REG, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("rstmid_wb_valid", bus.WB_VALID, 0);
    check("rstmid_busy", bus.BUSY, 0);
    check("rstmid_ccr", bus.CCR_NZVC, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    start_op(DIVU, WORD, 16'h6000, 32'd7, 32'd100, 32'd0);
    check("rearm_busy", bus.BUSY, 1);
    div_rdy(32'd14, 32'd2, 1'b0, 1'b0);
    check("rearm_wb_reg", bus.WB_REG, 6);
    check("rearm_wb_data", bus.WB_DATA, 32'h0002_000E);
    bus.WB_ACK = 1'b1;
    tick();
    bus.WB_ACK = 1'b0;
    tick();
    check("rearm_done", bus.DONE, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wf68k30l_div_writeback.md
# wf68k30l_div_writeback

Downstream stage of the division state machine in the WF68K30L ALU path. It captures operand signs when a DIVS/DIVU starts and consumes QUOTIENT/REMAINDER/VFLAG_DIV on DIV_RDY. It applies remainder sign correction and signed-overflow detection, then produces the 68030 condition codes. It sequences one or two register-file writes (Dq, then Dr) over a valid/ack handshake.

## Interface
- No parameters.
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous reset, active-low
- ALU_INIT  in  1  operation start strobe (same strobe the divider samples)
- OP_IN  in  7  opcode at ALU_INIT; only DIVS/DIVU arm the block
- OP_SIZE  in  2  WORD or LONG, sampled at ALU_INIT
- BIW_1  in  16  extension word, sampled at ALU_INIT: [14:12] Dq, [2:0] Dr, [10] 64-bit dividend
- OP1, OP2, OP3  in  32 each  divisor, dividend low, dividend high; only sign bits sampled at ALU_INIT
- DIV_ZERO  in  1  divisor-zero indication, valid with DIV_RDY
- DIV_RDY, QUOTIENT[31:0], REMAINDER[31:0], VFLAG_DIV  in  divider results
- WB_ACK  in  1  register file accepts the current write
- WB_VALID  out  1  write request; reset 0
- WB_REG  out  3  destination data register; reset 0
- WB_DATA  out  32  write data, always long; reset 0
- CCR_NZVC  out  4  flags; reset 0
- CCR_VALID  out  1  one-cycle strobe, CCR_NZVC valid; reset 0
- TRAP_DIVZERO  out  1  one-cycle strobe; reset 0
- BUSY  out  1  high in every state except IDLE; reset 0
- DONE  out  1  one-cycle completion strobe; reset 0

## Operation
- States: IDLE, ARMED, WB_Q, WB_R, FIN.
- IDLE→ARMED on ALU_INIT with OP_IN ∈ {DIVS, DIVU}. Latch the fields below:
  - op, size, Dq, Dr, BIW_1[10].
  - Dividend sign: OP3[31] if LONG and BIW_1[10], else OP2[31].
  - Divisor sign: OP1[15] for WORD, OP1[31] for LONG.
- ALU_INIT in ARMED re-latches (restart). ALU_INIT in WB_Q/WB_R/FIN is ignored.
- ARMED, on DIV_RDY:
  - If DIV_ZERO: pulse TRAP_DIVZERO, no CCR_VALID, no write, go to FIN.
  - Otherwise compute ovf = VFLAG_DIV | signed_ovf.
  - If ovf: CCR_NZVC=0010, CCR_VALID, no write, go to FIN.
  - Otherwise: CCR N = quotient MSB (bit 15 WORD, bit 31 LONG), Z = quotient field ==0, V=0, C=0. Assert CCR_VALID and go to WB_Q.
- signed_ovf (DIVS only; QUOTIENT is already sign-adjusted, REMAINDER is a magnitude):
  - WORD: QUOTIENT as signed 32-bit outside [-32768, 32767].
  - LONG, signs equal: QUOTIENT[31]=1.
  - LONG, signs differ: QUOTIENT≠0 and QUOTIENT[31]=0.
- Remainder R = DIVS and dividend negative ? −REMAINDER (two's complement, 32-bit) : REMAINDER.
- WB_Q write:
  - WORD: WB_REG=Dq, WB_DATA={R[15:0], QUOTIENT[15:0]}.
  - LONG: WB_REG=Dq, WB_DATA=QUOTIENT.
- Leaving WB_Q on WB_ACK: go to WB_R if LONG and Dr≠Dq, else FIN.
- WB_R write: WB_REG=Dr, WB_DATA=R. Go to FIN on WB_ACK.
- Dr==Dq in LONG: only the quotient is written.
- FIN: DONE=1 for one cycle, then IDLE.

## Timing
- DIV_RDY at edge N: CCR_VALID/TRAP_DIVZERO high in cycle N+1. WB_VALID rises in N+1.
- WB_VALID, WB_REG and WB_DATA are registered and held stable until WB_ACK is sampled high. There is no combinational path from ack to valid.
- Back-to-back writes: the WB_R request appears in the cycle after the WB_Q ack.
- Minimum DIV_RDY→DONE: 2 cycles (trap/overflow), 2 cycles plus ack wait per write otherwise.
- DIV_RDY outside ARMED is ignored.
- Async reset mid-operation: all outputs 0 and state IDLE immediately. Any pending write is dropped.

## Configuration
- WF68K30L_DIVS_OVF_CHECK_EN defined: signed_ovf as above.
- Not defined: signed_ovf forced 0, so V comes only from VFLAG_DIV. Use this only when the divider guarantees the signed range.

## Structure
- Shared package wf68k30L_pkg.svh: the existing DIVS/DIVU/LONG/WORD constants, plus the new DIV_WB_STATES enum.
- One combinational sub-module, wf68k30l_div_signfix. It takes the latched signs, size, op, QUOTIENT and REMAINDER, and returns signed_ovf, R and the N/Z flags.

## Test plan
- DIVU.W, OP2=100, OP1=7, divider gives Q=14, R=2 → one write Dq, WB_DATA=0x0002000E, CCR=0000.
- DIVS.W, OP2=−7, OP1=2, Q=0xFFFFFFFD, REMAINDER=1 → WB_DATA=0xFFFFFFFD, CCR=1000.
- DIVS.L 32-bit, OP2=0x80000000, OP1=0xFFFFFFFF, Q=0x80000000 → CCR=0010, no WB_VALID, DONE. With the macro undefined: CCR=1000, write issued.
- DIVU.L 64-bit, Dq=2, Dr=1, Q=0x12345678, R=0x9 → Dq write then Dr write. Hold WB_ACK low 3 cycles: data stable.
- DIV_ZERO with DIV_RDY → TRAP_DIVZERO pulse, CCR_VALID=0, no write, DONE next cycle.
- RESET_N low while in WB_R → WB_VALID, BUSY=0 asynchronously. After release, a new ALU_INIT arms normally.
